alu_cmd_ctrl: RTL and testbench

Command controller that drives the system ALU from the UART receive byte stream and returns the ALU result to the UART transmitter. It parses command frames, loads the operands and the function code, and pulses the ALU enable. It then captures the 16-bit result on the ALU valid strobe and sends it as two bytes, low byte first. It sits between the UART RX parallel output, the ALU, and the UART TX parallel input.

---
 rtl/alu_cmd_ctrl.sv | 114 +++++++++++
 tb/tb_alu_cmd_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command controller: parses UART RX frames into ALU operands/function, pulses the
// ALU enable, captures the 16-bit result and returns it to UART TX low byte first.
module alu_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int FUN_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   output logic [DATA_WIDTH-1:0]   ALU_A,
   output logic [DATA_WIDTH-1:0]   ALU_B,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    ALU_EN,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VALID,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   input  logic                    TX_BUSY,
   output logic                    CMD_ERR
);

   localparam logic [DATA_WIDTH-1:0] OP_FULL  = DATA_WIDTH'('hCC);
   localparam logic [DATA_WIDTH-1:0] OP_REUSE = DATA_WIDTH'('hDD);

   typedef enum logic [3:0] {
      IDLE, GET_A, GET_B, GET_FUN, ALU_REQ, ALU_WAIT, TX_LO, WAIT_LO, TX_HI, WAIT_HI
   } state_t;

   state_t                  r_state, w_next;
   logic [2*DATA_WIDTH-1:0] r_result;
   logic [DATA_WIDTH-1:0]   r_a, r_b, r_tx_data;
   logic [FUN_WIDTH-1:0]    r_fun;
   logic                    r_busy_seen, r_cmd_err;
   logic                    w_ld_a, w_ld_b, w_ld_fun, w_cap, w_ld_hi, w_err, w_wait_st;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (RX_D_VLD) begin
            if (RX_P_DATA == OP_FULL)       w_next = GET_A;
            else if (RX_P_DATA == OP_REUSE) w_next = GET_FUN;
         end
         GET_A:    if (RX_D_VLD)      w_next = GET_B;
         GET_B:    if (RX_D_VLD)      w_next = GET_FUN;
         GET_FUN:  if (RX_D_VLD)      w_next = ALU_REQ;
         ALU_REQ:                     w_next = ALU_WAIT;
         ALU_WAIT: if (ALU_OUT_VALID) w_next = TX_LO;
         TX_LO:    if (!TX_BUSY)      w_next = WAIT_LO;
         WAIT_LO:  if (r_busy_seen && !TX_BUSY) w_next = TX_HI;
         TX_HI:    if (!TX_BUSY)      w_next = WAIT_HI;
         WAIT_HI:  if (r_busy_seen && !TX_BUSY) w_next = IDLE;
         default:                     w_next = IDLE;
      endcase
   end

   // output / load-strobe decode
   always_comb begin
      ALU_EN    = (r_state == ALU_REQ);
      TX_D_VLD  = ((r_state == TX_LO) || (r_state == TX_HI)) && !TX_BUSY;
      w_ld_a    = (r_state == GET_A)   && RX_D_VLD;
      w_ld_b    = (r_state == GET_B)   && RX_D_VLD;
      w_ld_fun  = (r_state == GET_FUN) && RX_D_VLD;
      w_cap     = (r_state == ALU_WAIT) && ALU_OUT_VALID;
      w_ld_hi   = (r_state == WAIT_LO) && (w_next == TX_HI);
      w_wait_st = (r_state == WAIT_LO) || (r_state == WAIT_HI);
      w_err     = 1'b0;
      if (RX_D_VLD) begin
         if (r_state == IDLE)
            w_err = (RX_P_DATA != OP_FULL) && (RX_P_DATA != OP_REUSE);
         else if (r_state >= ALU_REQ)
            w_err = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_fun       <= '0;
         r_result    <= '0;
         r_tx_data   <= '0;
         r_busy_seen <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         if (w_ld_a)   r_a   <= RX_P_DATA;
         if (w_ld_b)   r_b   <= RX_P_DATA;
         if (w_ld_fun) r_fun <= RX_P_DATA[FUN_WIDTH-1:0];
         if (w_cap) begin
            r_result  <= ALU_OUT;
            r_tx_data <= ALU_OUT[DATA_WIDTH-1:0];
         end else if (w_ld_hi) begin
            r_tx_data <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
         end
         // busy must be seen high before its fall counts as end of byte
         r_busy_seen <= (w_wait_st && (w_next == r_state)) ? (r_busy_seen | TX_BUSY) : 1'b0;
         r_cmd_err   <= w_err;
      end
   end

   assign ALU_A     = r_a;
   assign ALU_B     = r_b;
   assign ALU_FUN   = r_fun;
   assign TX_P_DATA = r_tx_data;
   assign CMD_ERR   = r_cmd_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered ALU stub and a UART TX busy stub.
module tb_alu_cmd_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
   logic [3:0]  ALU_FUN;
   logic        ALU_EN, TX_D_VLD, CMD_ERR;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VALID = 1'b0;
   logic        TX_BUSY = 1'b0;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, last_rx_cyc = 0, en_cyc = 0, en_cnt = 0, err_cnt = 0, tx_bad = 0;
   int tx_busy_len = 3, busy_cnt = 0;
   logic [7:0] en_a, en_b;
   logic [3:0] en_f;
   logic [7:0] tx_q[$];
   int         tx_cyc_q[$];

   alu_cmd_ctrl #(.DATA_WIDTH(8), .FUN_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cyc++;

   // registered ALU: result one cycle after enable
   always @(posedge clk) begin
      ALU_OUT_VALID <= ALU_EN;
      if (ALU_EN)
         case (ALU_FUN)
            4'd0:    ALU_OUT <= 16'(ALU_A) + 16'(ALU_B);
            4'd1:    ALU_OUT <= 16'(ALU_A) - 16'(ALU_B);
            4'd2:    ALU_OUT <= 16'(ALU_A) * 16'(ALU_B);
            default: ALU_OUT <= 16'h0;
         endcase
   end

   // UART TX stub: busy for tx_busy_len cycles after each accepted byte
   always @(posedge clk) begin
      if (TX_D_VLD) begin
         if (TX_BUSY) tx_bad++;
         tx_q.push_back(TX_P_DATA);
         tx_cyc_q.push_back(cyc);
         busy_cnt <= tx_busy_len;
         TX_BUSY  <= 1'b1;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         TX_BUSY  <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (RX_D_VLD) last_rx_cyc = cyc;
      if (ALU_EN) begin
         en_cnt++; en_cyc = cyc; en_a = ALU_A; en_b = ALU_B; en_f = ALU_FUN;
      end
      if (CMD_ERR) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
   endtask

   task automatic rx_idle();
      @(negedge clk);
      RX_D_VLD = 1'b0;
   endtask

   task automatic wait_tx(input string tag, input int n);
      int k = 0;
      while (tx_q.size() < n && k < 400) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_timeout"}, (k < 400), 1);
      repeat (tx_busy_len + 4) @(negedge clk);
   endtask

   task automatic clr();
      tx_q.delete();
      tx_cyc_q.delete();
      en_cnt  = 0;
      err_cnt = 0;
   endtask

   initial begin
      int lo_cyc;
      repeat (3) @(negedge clk);
      check("reset_outs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
      rst = 1'b0;
      @(negedge clk);

      // add, with latency checks
      clr();
      send(8'hCC); send(8'h12); send(8'h34); send(8'h00); rx_idle();
      wait_tx("add", 2);
      check("add_en_cnt", en_cnt, 1);
      check("add_operands", {en_a, en_b, en_f}, {8'h12, 8'h34, 4'h0});
      check("add_en_lat", en_cyc - last_rx_cyc, 1);
      check("add_tx_lat", tx_cyc_q[0] - last_rx_cyc, 3);
      check("add_tx_bytes", {tx_q.size(), tx_q[0], tx_q[1]}, {32'd2, 8'h46, 8'h00} >> 0);

      // subtract reusing operands, underflow
      clr();
      send(8'hDD); send(8'h01); rx_idle();
      wait_tx("sub", 2);
      check("sub_operands", {en_a, en_b, en_f}, {8'h12, 8'h34, 4'h1});
      check("sub_tx_bytes", {tx_q[0], tx_q[1]}, 16'hDEFF);
      check("sub_hold_ab", {ALU_A, ALU_B}, 16'h1234);

      // multiply, FUN byte upper bits ignored
      clr();
      send(8'hCC); send(8'hFF); send(8'hFF); send(8'hF2); rx_idle();
      wait_tx("mul", 2);
      check("mul_fun", ALU_FUN, 4'h2);
      check("mul_tx_bytes", {tx_q[0], tx_q[1]}, 16'h01FE);

      // bad opcode in IDLE, then a good frame
      clr();
      send(8'h55); rx_idle();
      repeat (4) @(negedge clk);
      check("bad_op_err", err_cnt, 1);
      check("bad_op_no_en", en_cnt, 0);
      send(8'hCC); send(8'h01); send(8'h02); send(8'h00); rx_idle();
      wait_tx("after_bad", 2);
      check("after_bad_tx", {tx_q[0], tx_q[1], en_cnt[7:0], err_cnt[7:0]}, 32'h0300_0101);

      // long TX busy with an RX byte injected during WAIT_LO
      clr();
      tx_busy_len = 10;
      send(8'hCC); send(8'h05); send(8'h03); send(8'h01); rx_idle();
      while (tx_q.size() < 1 && cyc < 5000) @(negedge clk);
      repeat (3) @(negedge clk);
      send(8'h77); rx_idle();
      wait_tx("busy", 2);
      check("busy_tx_cnt", tx_q.size(), 2);
      check("busy_tx_bytes", {tx_q[0], tx_q[1]}, 16'h0200);
      lo_cyc = tx_cyc_q[0];
      check("busy_hi_after_fall", (tx_cyc_q[1] - lo_cyc >= 11) && (tx_cyc_q[1] - lo_cyc <= 13), 1);
      check("busy_no_vld_when_busy", tx_bad, 0);
      check("busy_err_once", err_cnt, 1);
      check("busy_ops_kept", {ALU_A, ALU_B, ALU_FUN}, {8'h05, 8'h03, 4'h1});
      tx_busy_len = 3;

      // reset mid-frame clears operands asynchronously
      clr();
      send(8'hCC); send(8'h12); rx_idle();
      check("pre_rst_a", ALU_A, 8'h12);
      #2 rst = 1'b1;
      #1 check("rst_outs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
      @(negedge clk);
      rst = 1'b0;
      send(8'hDD); send(8'h00); rx_idle();
      wait_tx("post_rst", 2);
      check("post_rst_ops", {en_a, en_b, en_f, en_cnt[3:0]}, {8'h00, 8'h00, 4'h0, 4'h1});
      check("post_rst_tx", {tx_q[0], tx_q[1]}, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
